// File: rtl/pong_renderer.sv
// Pong game core: per-frame ball/paddle/score state machine plus a one-clock
// pixel pipeline that turns the vga_counter position into a registered RGB
// value with hsync/vsync delayed to stay aligned with it.
module pong_renderer #(
   parameter int H_ACTIVE     = 400,
   parameter int V_ACTIVE     = 600,
   parameter int BALL_SIZE    = 8,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_H     = 80,
   parameter int PADDLE_W     = 6,
   parameter int PADDLE_X     = 16,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [8:0]  hcounter,
   input  logic [10:0] vcounter,
   input  logic        display,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        btn_l_up,
   input  logic        btn_l_dn,
   input  logic        btn_r_up,
   input  logic        btn_r_dn,
   output logic [2:0]  rgb,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r
);

   typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

   localparam int SCW = $clog2(SERVE_FRAMES + 1);

   // 12-bit compare constants so that sums of 11-bit positions never wrap
   localparam logic [11:0] C_H    = 12'(H_ACTIVE);
   localparam logic [11:0] C_V    = 12'(V_ACTIVE);
   localparam logic [11:0] C_BS   = 12'(BALL_SIZE);
   localparam logic [11:0] C_SPD  = 12'(BALL_SPEED);
   localparam logic [11:0] C_PH   = 12'(PADDLE_H);
   localparam logic [11:0] C_PW   = 12'(PADDLE_W);
   localparam logic [11:0] C_PSPD = 12'(PADDLE_SPEED);
   localparam logic [11:0] C_PXL  = 12'(PADDLE_X);
   localparam logic [11:0] C_PXR  = 12'(H_ACTIVE - PADDLE_X - PADDLE_W);
   localparam logic [11:0] C_NET0 = 12'(H_ACTIVE / 2 - 1);
   localparam logic [11:0] C_NET1 = 12'(H_ACTIVE / 2);

   // 11-bit position constants
   localparam logic [10:0] C_BX0     = 11'(H_ACTIVE / 2 - BALL_SIZE / 2);
   localparam logic [10:0] C_BY0     = 11'(V_ACTIVE / 2 - BALL_SIZE / 2);
   localparam logic [10:0] C_PY0     = 11'((V_ACTIVE - PADDLE_H) / 2);
   localparam logic [10:0] C_BX_LHIT = 11'(PADDLE_X + PADDLE_W);
   localparam logic [10:0] C_BX_RHIT = 11'(H_ACTIVE - PADDLE_X - PADDLE_W - BALL_SIZE);
   localparam logic [10:0] C_BY_MAX  = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic [10:0] C_PY_MAX  = 11'(V_ACTIVE - PADDLE_H);
   localparam logic [10:0] C_BSTEP   = 11'(BALL_SPEED);
   localparam logic [10:0] C_PSTEP   = 11'(PADDLE_SPEED);
   localparam logic [3:0]  C_WIN     = 4'(WIN_SCORE);
   localparam logic [SCW-1:0] C_SERVE_LAST = SCW'(SERVE_FRAMES - 1);

   state_t         r_state;
   logic [SCW-1:0] r_serve_cnt;
   logic [10:0]    r_ball_x;
   logic [10:0]    r_ball_y;
   logic           r_vx_neg;
   logic           r_vy_neg;
   logic [10:0]    r_pad_l;
   logic [10:0]    r_pad_r;
   logic [3:0]     r_score_l;
   logic [3:0]     r_score_r;
   logic [2:0]     r_rgb;
   logic           r_hsync_o;
   logic           r_vsync_o;

   logic        w_frame_tick;
   logic [11:0] w_bx;
   logic [11:0] w_by;
   logic [11:0] w_pl;
   logic [11:0] w_pr;
   logic [11:0] w_h;
   logic [11:0] w_v;
   logic        w_miss_l;
   logic        w_miss_r;
   logic        w_hit_l;
   logic        w_hit_r;
   logic [10:0] w_ball_y_nx;
   logic        w_vy_neg_nx;
   logic [10:0] w_pad_l_nx;
   logic [10:0] w_pad_r_nx;
   logic        w_ball_px;
   logic        w_pad_px;
   logic        w_net_px;
   logic [2:0]  w_rgb_nx;

   function automatic logic [10:0] f_paddle(input logic [10:0] y, input logic up,
                                            input logic dn);
      logic [11:0] y12;
      y12      = {1'b0, y};
      f_paddle = y;
      if (up && !dn)
         f_paddle = (y12 < C_PSPD) ? '0 : y - C_PSTEP;
      else if (dn && !up)
         f_paddle = (y12 + C_PSPD > {1'b0, C_PY_MAX}) ? C_PY_MAX : y + C_PSTEP;
   endfunction

   assign w_frame_tick = (hcounter == '0) && ({1'b0, vcounter} == C_V);
   assign w_bx = {1'b0, r_ball_x};
   assign w_by = {1'b0, r_ball_y};
   assign w_pl = {1'b0, r_pad_l};
   assign w_pr = {1'b0, r_pad_r};
   assign w_h  = {3'b000, hcounter};
   assign w_v  = {1'b0, vcounter};

   // Game-rule decisions for the coming tick, all from pre-tick values
   always_comb begin
      w_miss_l = r_vx_neg && (w_bx < C_SPD);
      w_miss_r = !r_vx_neg && (w_bx + C_BS > C_H - C_SPD);
      w_hit_l  = r_vx_neg && (w_bx < C_PXL + C_PW) && (w_bx + C_BS > C_PXL)
                 && (w_by < w_pl + C_PH) && (w_by + C_BS > w_pl);
      w_hit_r  = !r_vx_neg && (w_bx < C_PXR + C_PW) && (w_bx + C_BS > C_PXR)
                 && (w_by < w_pr + C_PH) && (w_by + C_BS > w_pr);
      w_ball_y_nx = r_ball_y + C_BSTEP;
      w_vy_neg_nx = r_vy_neg;
      if (r_vy_neg) begin
         if (w_by < C_SPD) begin
            w_ball_y_nx = '0;
            w_vy_neg_nx = 1'b0;
         end else begin
            w_ball_y_nx = r_ball_y - C_BSTEP;
         end
      end else if (w_by + C_BS > C_V - C_SPD) begin
         w_ball_y_nx = C_BY_MAX;
         w_vy_neg_nx = 1'b1;
      end
      w_pad_l_nx = f_paddle(r_pad_l, btn_l_up, btn_l_dn);
      w_pad_r_nx = f_paddle(r_pad_r, btn_r_up, btn_r_dn);
   end

   // Pixel classification and colour priority for the current counter position
   always_comb begin
      w_ball_px = (r_state != S_OVER) && (w_h >= w_bx) && (w_h < w_bx + C_BS)
                  && (w_v >= w_by) && (w_v < w_by + C_BS);
      w_pad_px  = ((w_h >= C_PXL) && (w_h < C_PXL + C_PW)
                   && (w_v >= w_pl) && (w_v < w_pl + C_PH))
                  || ((w_h >= C_PXR) && (w_h < C_PXR + C_PW)
                   && (w_v >= w_pr) && (w_v < w_pr + C_PH));
      w_net_px  = ((w_h == C_NET0) || (w_h == C_NET1)) && !vcounter[4];
      w_rgb_nx  = 3'b000;
      if (display) begin
         if (w_ball_px)      w_rgb_nx = 3'b110;
         else if (w_pad_px)  w_rgb_nx = 3'b111;
         else if (w_net_px)  w_rgb_nx = 3'b010;
      end
   end

   // Registered pixel and sync, one clock behind the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb     <= '0;
         r_hsync_o <= 1'b0;
         r_vsync_o <= 1'b0;
      end else begin
         r_rgb     <= w_rgb_nx;
         r_hsync_o <= hsync;
         r_vsync_o <= vsync;
      end
   end

   // Game FSM, advanced once per frame tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_SERVE;
         r_serve_cnt <= '0;
         r_ball_x    <= C_BX0;
         r_ball_y    <= C_BY0;
         r_vx_neg    <= 1'b0;
         r_vy_neg    <= 1'b0;
         r_pad_l     <= C_PY0;
         r_pad_r     <= C_PY0;
         r_score_l   <= '0;
         r_score_r   <= '0;
      end else if (w_frame_tick) begin
         case (r_state)
            S_SERVE: begin
               r_pad_l  <= w_pad_l_nx;
               r_pad_r  <= w_pad_r_nx;
               r_ball_x <= C_BX0;
               r_ball_y <= C_BY0;
               if (r_serve_cnt == C_SERVE_LAST) begin
                  r_serve_cnt <= '0;
                  r_state     <= S_PLAY;
               end else begin
                  r_serve_cnt <= r_serve_cnt + 1'b1;
               end
            end
            S_PLAY: begin
               r_pad_l  <= w_pad_l_nx;
               r_pad_r  <= w_pad_r_nx;
               r_ball_y <= w_ball_y_nx;
               r_vy_neg <= w_vy_neg_nx;
               if (w_miss_l) begin
                  r_score_r <= (r_score_r < C_WIN) ? r_score_r + 4'd1 : r_score_r;
                  r_state   <= S_POINT;
               end else if (w_miss_r) begin
                  r_score_l <= (r_score_l < C_WIN) ? r_score_l + 4'd1 : r_score_l;
                  r_state   <= S_POINT;
               end else if (w_hit_l) begin
                  r_ball_x <= C_BX_LHIT;
                  r_vx_neg <= 1'b0;
               end else if (w_hit_r) begin
                  r_ball_x <= C_BX_RHIT;
                  r_vx_neg <= 1'b1;
               end else begin
                  r_ball_x <= r_vx_neg ? r_ball_x - C_BSTEP : r_ball_x + C_BSTEP;
               end
            end
            S_POINT: begin
               r_pad_l <= w_pad_l_nx;
               r_pad_r <= w_pad_r_nx;
               if ((r_score_l == C_WIN) || (r_score_r == C_WIN)) begin
                  r_state <= S_OVER;
               end else begin
                  // vx is left alone: at a miss the ball is already heading
                  // toward the side that lost the point
                  r_state     <= S_SERVE;
                  r_serve_cnt <= '0;
                  r_ball_x    <= C_BX0;
                  r_ball_y    <= C_BY0;
               end
            end
            default: begin
               r_state <= S_OVER;
            end
         endcase
      end
   end

   assign rgb     = r_rgb;
   assign hsync_o = r_hsync_o;
   assign vsync_o = r_vsync_o;
   assign score_l = r_score_l;
   assign score_r = r_score_r;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: drives the counters directly, uses a single
// (hcounter=0, vcounter=600) clock as one frame tick, and probes pixels.
module tb_pong_renderer;

   logic        clk;
   logic        rst_n;
   logic [8:0]  hcounter;
   logic [10:0] vcounter;
   logic        display;
   logic        hsync;
   logic        vsync;
   logic        btn_l_up;
   logic        btn_l_dn;
   logic        btn_r_up;
   logic        btn_r_dn;
   logic [2:0]  rgb;
   logic        hsync_o;
   logic        vsync_o;
   logic [3:0]  score_l;
   logic [3:0]  score_r;

   int errors = 0;
   int checks = 0;

   pong_renderer #(
      .H_ACTIVE    (400),
      .V_ACTIVE    (600),
      .SERVE_FRAMES(60),
      .WIN_SCORE   (9)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .hcounter(hcounter),
      .vcounter(vcounter),
      .display (display),
      .hsync   (hsync),
      .vsync   (vsync),
      .btn_l_up(btn_l_up),
      .btn_l_dn(btn_l_dn),
      .btn_r_up(btn_r_up),
      .btn_r_dn(btn_r_dn),
      .rgb     (rgb),
      .hsync_o (hsync_o),
      .vsync_o (vsync_o),
      .score_l (score_l),
      .score_r (score_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic frame(input int n);
      for (int i = 0; i < n; i++) begin
         hcounter = 9'd0;
         vcounter = 11'd600;
         display  = 1'b0;
         @(posedge clk);
         #1;
         vcounter = 11'd0;
      end
   endtask

   task automatic pix(input string tag, input int h, input int v, input logic [2:0] exp);
      hcounter = 9'(h);
      vcounter = 11'(v);
      display  = 1'b1;
      @(posedge clk);
      #1;
      chk(tag, {5'd0, rgb}, {5'd0, exp});
      display  = 1'b0;
      hcounter = 9'd0;
      vcounter = 11'd0;
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; hcounter = '0; vcounter = '0; display = 1'b0;
      hsync = 1'b0; vsync = 1'b0;
      btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rgb", {5'd0, rgb}, 8'd0);
      chk("rst_score_l", {4'd0, score_l}, 8'd0);
      chk("rst_score_r", {4'd0, score_r}, 8'd0);
      chk("rst_hsync_o", {7'd0, hsync_o}, 8'd0);
      rst_n = 1'b1;

      // one frame, no buttons: ball at (196..203, 296..303), paddles y 260..339
      frame(1);
      pix("ball_pix", 198, 300, 3'b110);
      pix("ball_over_net", 199, 300, 3'b110);
      pix("ball_right_edge", 204, 300, 3'b000);
      pix("lpad_top", 18, 260, 3'b111);
      pix("lpad_above", 18, 259, 3'b000);
      pix("rpad", 380, 300, 3'b111);
      pix("net_on", 200, 0, 3'b010);
      pix("net_gap", 199, 16, 3'b000);
      hcounter = 9'd198; vcounter = 11'd300; display = 1'b0;
      @(posedge clk); #1;
      chk("blank", {5'd0, rgb}, 8'd0);
      hsync = 1'b1;
      @(posedge clk); #1;
      chk("hsync_dly", {7'd0, hsync_o}, 8'd1);
      hsync = 1'b0; vsync = 1'b1;
      @(posedge clk); #1;
      chk("vsync_dly", {7'd0, vsync_o}, 8'd1);
      chk("hsync_dly_low", {7'd0, hsync_o}, 8'd0);
      vsync = 1'b0;

      // paddle clamps: left up 70 frames -> 0, right down 70 frames -> 520
      do_reset();
      btn_l_up = 1'b1; btn_r_dn = 1'b1;
      frame(70);
      btn_l_up = 1'b0; btn_r_dn = 1'b0;
      pix("lpad_clamp0", 18, 0, 3'b111);
      pix("lpad_clamp79", 18, 79, 3'b111);
      pix("lpad_clamp80", 18, 80, 3'b000);
      pix("rpad_clamp599", 380, 599, 3'b111);
      pix("rpad_clamp519", 380, 519, 3'b000);
      btn_l_dn = 1'b1;
      frame(5);
      pix("lpad_dn20", 18, 20, 3'b111);
      pix("lpad_dn19", 18, 19, 3'b000);
      btn_l_up = 1'b1;
      frame(5);
      btn_l_up = 1'b0; btn_l_dn = 1'b0;
      pix("lpad_both19", 18, 19, 3'b000);
      pix("lpad_both99", 18, 99, 3'b111);
      pix("lpad_both100", 18, 100, 3'b000);

      // right miss: 60 serve ticks, ball reaches x=392 after 98 steps, miss on tick 159
      do_reset();
      frame(158);
      chk("pre_miss_score_l", {4'd0, score_l}, 8'd0);
      pix("pre_miss_ball", 392, 492, 3'b110);
      frame(1);
      chk("miss_score_l", {4'd0, score_l}, 8'd1);
      chk("miss_score_r", {4'd0, score_r}, 8'd0);
      frame(1);
      pix("recentred", 196, 300, 3'b110);
      frame(59);
      pix("serve_hold", 196, 300, 3'b110);
      frame(1);
      pix("serve_end", 196, 300, 3'b110);
      frame(1);
      pix("launch_left_edge", 197, 300, 3'b000);
      pix("launch_right_edge", 205, 300, 3'b110);

      // right paddle to y=468, hit on tick 149 with ball at (372,472)
      do_reset();
      btn_r_dn = 1'b1;
      frame(52);
      btn_r_dn = 1'b0;
      pix("rpad_468", 380, 468, 3'b111);
      pix("rpad_467", 380, 467, 3'b000);
      frame(96);
      pix("pre_hit_ball", 372, 472, 3'b110);
      frame(1);
      pix("hit_snap", 370, 474, 3'b110);
      pix("hit_snap_left", 369, 474, 3'b000);
      pix("hit_pad_face", 378, 474, 3'b111);
      frame(1);
      pix("hit_moving_left", 368, 476, 3'b110);
      pix("hit_moved_off", 376, 476, 3'b000);
      chk("hit_score_l", {4'd0, score_l}, 8'd0);
      chk("hit_score_r", {4'd0, score_r}, 8'd0);

      // nine identical 160-tick rallies won by the left player -> OVER
      do_reset();
      frame(1439);
      chk("ninth_score_l", {4'd0, score_l}, 8'd9);
      pix("ninth_ball", 392, 494, 3'b110);
      frame(1);
      chk("over_score_l", {4'd0, score_l}, 8'd9);
      pix("over_ball_hidden", 392, 494, 3'b000);
      btn_l_up = 1'b1;
      frame(20);
      btn_l_up = 1'b0;
      pix("over_pad_frozen", 18, 260, 3'b111);
      pix("over_pad_frozen_above", 18, 259, 3'b000);
      chk("over_score_l_hold", {4'd0, score_l}, 8'd9);
      chk("over_score_r_hold", {4'd0, score_r}, 8'd0);

      // asynchronous reset in the middle of a visible line
      hcounter = 9'd18; vcounter = 11'd260; display = 1'b1; hsync = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_rgb", {5'd0, rgb}, 8'd7);
      chk("pre_rst_hsync_o", {7'd0, hsync_o}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rgb", {5'd0, rgb}, 8'd0);
      chk("async_score_l", {4'd0, score_l}, 8'd0);
      chk("async_hsync_o", {7'd0, hsync_o}, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; hsync = 1'b0; display = 1'b0;
      pix("async_ball_centre", 196, 296, 3'b110);
      pix("async_ball_left", 195, 296, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
